// File: rtl/lsu_port_b_master.sv
// ---------------------------------------------------------------------------
// lsu_port_b_master
//   Load/store initiator for the data port (port B) of the shared I/D RAM.
//   Takes one RV32 load/store at a time, checks alignment and funct3,
//   extracts and extends load lanes, and places store data. With
//   RMW_ENABLE=1 partial stores read the word, merge the new lane(s) and
//   write the full word back; with RMW_ENABLE=0 they issue one lane-masked
//   write.
//
// Ports
//   clk_i, reset_ni                 clock, async active-low reset
//   req_valid_i / req_ready_o       request handshake (ready only in IDLE)
//   req_we_i, req_funct3_i,
//   req_addr_i, req_wdata_i         request payload
//   resp_valid_o                    one-cycle completion pulse
//   resp_rdata_o, resp_err_o        extended load data / error flag
//   mem_addr_o, mem_din_o, mem_web_o registered RAM port B controls
//   mem_dout_i                      RAM port B read data (1-cycle latency)
// ---------------------------------------------------------------------------
module lsu_port_b_master #(
    parameter int RMW_ENABLE = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_din_o,
    output logic [3:0]        mem_web_o,
    input  logic [31:0]       mem_dout_i
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       wdata_q, wdata_d;     // only the partial-store lanes are needed later
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic [3:0]        mem_web_q, mem_web_d;

    logic acc_illegal, acc_misal, acc_err, acc_word, acc_direct;

    // Lane extraction with sign/zero extension for loads.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'h0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Overlay the store lane(s) onto the word read back from RAM.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] a, input logic [15:0] wd);
        merge = w;
        if (f3[1:0] == 2'b00) merge[{a, 3'b000} +: 8]        = wd[7:0];
        else                  merge[{a[1], 4'b0000} +: 16]   = wd;
    endfunction

    always_comb begin
        acc_illegal = req_we_i ? (req_funct3_i >= 3'b011)
                               : (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11);
        acc_misal   = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0])
                   || (req_funct3_i == 3'b010 && req_addr_i[1:0] != 2'b00);
        acc_err     = acc_illegal || acc_misal;
        acc_word    = (req_funct3_i == 3'b010);
        // Stores that go straight to WRITE: full words, or any store when the RAM masks bytes.
        acc_direct  = acc_word || (RMW_ENABLE == 0);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 32'h0;
            mem_web_q  <= 4'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_web_q  <= mem_web_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_web_d  = 4'h0;       // write enable lives for exactly the WRITE cycle
        unique case (state_q)
            IDLE: if (req_valid_i) begin
                we_d    = req_we_i;
                f3_d    = req_funct3_i;
                off_d   = req_addr_i[1:0];
                wdata_d = req_wdata_i[15:0];
                rdata_d = 32'h0;
                err_d   = acc_err;
                if (acc_err) begin
                    state_d = RESP;
                end else begin
                    mem_addr_d = {req_addr_i[ADDR_W-1:2], 2'b00};
                    if (req_we_i && acc_direct) begin
                        state_d = WRITE;
                        unique case (req_funct3_i[1:0])
                            2'b00: begin
                                mem_web_d = 4'b0001 << req_addr_i[1:0];
                                mem_din_d = {4{req_wdata_i[7:0]}};
                            end
                            2'b01: begin
                                mem_web_d = 4'b0011 << {req_addr_i[1], 1'b0};
                                mem_din_d = {2{req_wdata_i[15:0]}};
                            end
                            default: begin
                                mem_web_d = 4'b1111;
                                mem_din_d = req_wdata_i;
                            end
                        endcase
                    end else begin
                        state_d = ADDR;  // load, or partial store needing the old word
                    end
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                if (we_q) begin
                    mem_din_d = merge(mem_dout_i, f3_q, off_q, wdata_q);
                    mem_web_d = 4'b1111;
                    state_d   = WRITE;
                end else begin
                    rdata_d = load_ext(mem_dout_i, f3_q, off_q);
                    state_d = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == IDLE) && reset_ni;
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_din_o    = mem_din_q;
    assign mem_web_o    = mem_web_q;

endmodule

// File: tb/tb_lsu_port_b_master.sv
module tb_lsu_port_b_master;
    logic        clk = 1'b0;
    logic        reset_ni;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
    logic [3:0]  mem_web;

    lsu_port_b_master #(.RMW_ENABLE(1), .ADDR_W(32)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_web_o(mem_web),
        .mem_dout_i(mem_dout)
    );

    always #5 clk = ~clk;

    // RAM model: registered read when web==0, full-word write when any web bit set.
    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        if (mem_web != 4'h0) ram[mem_addr[7:2]] <= mem_din;
        else                 mem_dout <= ram[mem_addr[7:2]];
    end

    typedef struct { logic [31:0] rdata; logic err; int lat; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] din; logic [3:0] web; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: observes accepts, RAM writes and responses; checks against queues.
    always @(negedge clk) begin
        if (reset_ni) begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (mem_web != 4'h0) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_web", {28'h0, mem_web}, 32'h0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_din", mem_din, w.din);
                    chk("wr_web", {28'h0, mem_web}, {28'h0, w.web});
                end
            end
            if (resp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
                    chk("resp_latency", cyc - acc_cyc, r.lat);
                end
            end
        end
    end

    task automatic drive(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("accept_timeout", 32'h1, 32'h0);
        @(posedge clk);
        #1;
        // Scramble inputs after accept: the DUT must use its latched copy.
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
        req_addr = 32'hFFFF_FFFF; req_wdata = $urandom;
    endtask

    task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                         input bit [31:0] er, input bit ee, input int lat,
                         input bit wr, input bit [31:0] wa, input bit [31:0] wdin, input bit [3:0] wweb);
        rsp_q.push_back('{rdata: er, err: ee, lat: lat});
        if (wr) wr_q.push_back('{addr: wa, din: wdin, web: wweb});
        drive(we, f3, a, wd);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
        chk("drain_rsp", rsp_q.size(), 0);
        chk("drain_wr", wr_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[4]  = 32'h80FF7F01;   // 0x10
        ram[8]  = 32'h11223344;   // 0x20
        mem_dout = 32'h0;
        reset_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        chk("rst_mem_web", {28'h0, mem_web}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        @(negedge clk); reset_ni = 1'b1;
        #1 chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

        // Loads on word 0x80FF7F01 (issued back-to-back; valid held across busy cycles)
        issue(0, 3'b010, 32'h10, 0, 32'h80FF7F01, 0, 3, 0, 0, 0, 0);
        issue(0, 3'b000, 32'h13, 0, 32'hFFFFFF80, 0, 3, 0, 0, 0, 0);
        issue(0, 3'b100, 32'h13, 0, 32'h00000080, 0, 3, 0, 0, 0, 0);
        issue(0, 3'b001, 32'h12, 0, 32'hFFFF80FF, 0, 3, 0, 0, 0, 0);
        issue(0, 3'b101, 32'h10, 0, 32'h00007F01, 0, 3, 0, 0, 0, 0);
        issue(0, 3'b000, 32'h11, 0, 32'h0000007F, 0, 3, 0, 0, 0, 0);
        // Read-modify-write partial stores
        issue(1, 3'b000, 32'h21, 32'hFFFF_FFAB, 0, 0, 4, 1, 32'h20, 32'h1122AB44, 4'hF);
        issue(0, 3'b010, 32'h20, 0, 32'h1122AB44, 0, 3, 0, 0, 0, 0);
        issue(1, 3'b001, 32'h22, 32'h1234CAFE, 0, 0, 4, 1, 32'h20, 32'hCAFEAB44, 4'hF);
        issue(0, 3'b010, 32'h20, 0, 32'hCAFEAB44, 0, 3, 0, 0, 0, 0);
        // Full-word store
        issue(1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 0, 2, 1, 32'h40, 32'hDEADBEEF, 4'hF);
        issue(0, 3'b010, 32'h40, 0, 32'hDEADBEEF, 0, 3, 0, 0, 0, 0);
        // Errors: no RAM write expected, response straight from IDLE
        issue(0, 3'b010, 32'h42, 0, 0, 1, 1, 0, 0, 0, 0);
        issue(1, 3'b001, 32'h43, 32'h5555, 0, 1, 1, 0, 0, 0, 0);
        issue(0, 3'b011, 32'h40, 0, 0, 1, 1, 0, 0, 0, 0);
        issue(1, 3'b100, 32'h40, 32'h77, 0, 1, 1, 0, 0, 0, 0);
        issue(1, 3'b010, 32'h41, 32'h99, 0, 1, 1, 0, 0, 0, 0);
        drain();

        // Reset during the WRITE cycle of a SW: write aborted, no response.
        wr_q.push_back('{addr: 32'h44, din: 32'h12345678, web: 4'hF});
        drive(1, 3'b010, 32'h44, 32'h12345678);
        @(negedge clk);
        #2 reset_ni = 1'b0;
        #1;
        chk("rst_mid_web", {28'h0, mem_web}, 32'h0);
        chk("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        #1 chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        issue(0, 3'b010, 32'h44, 0, 32'h00000000, 0, 3, 0, 0, 0, 0);
        issue(0, 3'b010, 32'h10, 0, 32'h80FF7F01, 0, 3, 0, 0, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
